apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Two-requester APB master that shares one APB slave port, such as our APB slave memory, between two local command sources.
- Arbitrates round-robin, sequences the IDLE -> SETUP -> ACCESS protocol, waits on pready, and returns read data and error status to the winning requester.
- Aborts any ACCESS phase that exceeds a programmable timeout.

Parameters:
addr_width, 8, APB address width
data_width, 8, APB data width
TIMEOUT, 16, max ACCESS-phase cycles without pready before abort (>=2)

Ports:
pclk  input  1  APB clock, all logic on rising edge
preset_n  input  1  reset: asynchronous, active-high (asserted = 1)
req0_valid  input  1  requester 0 command pending; held until req0_ready
req0_write  input  1  requester 0: 1 write, 0 read
req0_addr  input  addr_width  requester 0 address
req0_wdata  input  data_width  requester 0 write data
req0_ready  output  1  one-cycle pulse: requester 0 command accepted
req0_done  output  1  one-cycle pulse: requester 0 transfer complete
req0_rdata  output  data_width  read data, valid with req0_done
req0_err  output  1  error status, valid with req0_done
req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, req1_done, req1_rdata, req1_err: same as requester 0, for requester 1
paddr  output  addr_width  APB address
pwrite  output  1  APB direction
pwdata  output  data_width  APB write data
pselx  output  1  APB select
penable  output  1  APB enable
prdata  input  data_width  APB read data
pready  input  1  APB slave ready
pslave_error  input  1  APB slave error, sampled with pready

Behaviour:
- All outputs registered. Reset (preset_n=1, async) immediately forces all outputs to 0, state=IDLE, timeout counter=0, last_grant=1.
- A reset mid-transfer drops the transfer. No done pulse is issued for it.
- FSM states: IDLE, SETUP, ACCESS.
- Arbitration (evaluated in IDLE, and in ACCESS on the completion cycle):
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins.
  - last_grant updates to the winner. After reset, requester 0 wins the first tie.
- On a grant edge:
  - Latch addr, write and wdata onto paddr, pwrite and pwdata.
  - Set pselx=1, penable=0, state=SETUP.
  - Pulse the winner's reqN_ready for exactly that cycle.
  - The requester may change or drop its command after seeing ready.
- SETUP -> ACCESS unconditionally after one cycle: penable=1, pselx stays 1, counter=0.
- ACCESS:
  - paddr, pwrite and pwdata are held stable.
  - Each cycle with pready=0, the counter increments.
- Completion, when pready=1 is sampled:
  - On the next cycle, the owner's reqN_done=1.
  - reqN_rdata = prdata for reads, 0 for writes.
  - reqN_err = pslave_error.
  - penable -> 0.
  - If a new grant is available, go directly to SETUP: pselx stays 1 and the new command is latched (back-to-back).
  - Otherwise go to IDLE with pselx=0.
- Timeout: if pready is still 0 when the counter reaches TIMEOUT-1:
  - Next cycle: done=1, err=1, rdata=0, pselx=0, penable=0.
  - State -> IDLE. No back-to-back grant after a timeout.
- reqN_rdata and reqN_err hold their last values between done pulses. done, ready and penable are never asserted for more than one transfer cycle each.
- Minimum latency with zero wait states: valid sampled at edge k -> SETUP at k+1 -> ACCESS at k+2 with pready=1 -> done at k+3.
- paddr and pwdata retain their values in IDLE; pwrite is held.

Test Plan:
- Single write: req0 write addr=0x12, wdata=0xA5, slave pready=1 immediately -> req0_ready at k+1; pselx=1 and penable=0 at k+1; penable=1 at k+2; req0_done=1 and req0_err=0 at k+3; slave memory[0x12]=0xA5.
- Read with 3 wait states: req1 read addr=0x12, pready asserted on the 4th ACCESS cycle with prdata=0xA5 -> paddr stable throughout ACCESS; req1_done one cycle after pready with req1_rdata=0xA5.
- Simultaneous requests from reset, both held for 4 transfers -> grant order 0,1,0,1; back-to-back SETUP with pselx never dropping; each requester sees exactly 2 ready and 2 done pulses.
- Timeout: pready held 0 with TIMEOUT=16 -> done and err=1 exactly 16 ACCESS cycles after entering ACCESS; pselx=0; rdata=0; next request proceeds normally.
- Slave error: pslave_error=1 with pready=1 on a read -> reqN_err=1 with done; rdata=prdata.
- Reset mid-ACCESS (preset_n=1 asynchronously) -> pselx, penable and all done/ready immediately 0; after release, a tie grants requester 0 first.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration, IDLE/SETUP/ACCESS sequencing,
// per-requester done/rdata/err return, and ACCESS-phase timeout abort.
module apb_master_arbiter #(
   parameter int addr_width = 8,
   parameter int data_width = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic                  pclk,
   input  logic                  preset_n,
   input  logic                  req0_valid,
   input  logic                  req0_write,
   input  logic [addr_width-1:0] req0_addr,
   input  logic [data_width-1:0] req0_wdata,
   output logic                  req0_ready,
   output logic                  req0_done,
   output logic [data_width-1:0] req0_rdata,
   output logic                  req0_err,
   input  logic                  req1_valid,
   input  logic                  req1_write,
   input  logic [addr_width-1:0] req1_addr,
   input  logic [data_width-1:0] req1_wdata,
   output logic                  req1_ready,
   output logic                  req1_done,
   output logic [data_width-1:0] req1_rdata,
   output logic                  req1_err,
   output logic [addr_width-1:0] paddr,
   output logic                  pwrite,
   output logic [data_width-1:0] pwdata,
   output logic                  pselx,
   output logic                  penable,
   input  logic [data_width-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslave_error
);
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

   state_t                      r_state, w_state_n;
   logic [CW-1:0]               r_cnt, w_cnt_n;
   logic                        r_last, w_last_n;
   logic                        r_owner, w_owner_n;
   logic [addr_width-1:0]       r_paddr, w_paddr_n;
   logic                        r_pwrite, w_pwrite_n;
   logic [data_width-1:0]       r_pwdata, w_pwdata_n;
   logic                        r_psel, w_psel_n;
   logic                        r_pen, w_pen_n;
   logic [1:0]                  r_ready, w_ready_n;
   logic [1:0]                  r_done, w_done_n;
   logic [1:0]                  r_err, w_err_n;
   logic [1:0][data_width-1:0]  r_rdata, w_rdata_n;

   logic w_any, w_win, w_grant;

   // Tie goes to the requester that did not win last; r_last resets to 1 so 0 wins first.
   assign w_any = req0_valid | req1_valid;
   assign w_win = (req0_valid & req1_valid) ? ~r_last : req1_valid;

   always_comb begin
      w_state_n  = r_state;
      w_cnt_n    = r_cnt;
      w_last_n   = r_last;
      w_owner_n  = r_owner;
      w_paddr_n  = r_paddr;
      w_pwrite_n = r_pwrite;
      w_pwdata_n = r_pwdata;
      w_psel_n   = r_psel;
      w_pen_n    = 1'b0;
      w_ready_n  = 2'b00;
      w_done_n   = 2'b00;
      w_err_n    = r_err;
      w_rdata_n  = r_rdata;
      w_grant    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_psel_n = 1'b0;
            w_grant  = w_any;
         end
         S_SETUP: begin
            w_state_n = S_ACCESS;
            w_pen_n   = 1'b1;
            w_cnt_n   = '0;
         end
         S_ACCESS: begin
            if (pready) begin
               w_done_n[r_owner]  = 1'b1;
               w_rdata_n[r_owner] = r_pwrite ? '0 : prdata;
               w_err_n[r_owner]   = pslave_error;
               w_state_n          = S_IDLE;
               w_psel_n           = 1'b0;
               w_grant            = w_any;
            end else if (r_cnt == CW'(TIMEOUT - 1)) begin
               // Abort: no back-to-back grant, slave is assumed hung.
               w_done_n[r_owner]  = 1'b1;
               w_rdata_n[r_owner] = '0;
               w_err_n[r_owner]   = 1'b1;
               w_state_n          = S_IDLE;
               w_psel_n           = 1'b0;
            end else begin
               w_cnt_n = r_cnt + 1'b1;
               w_pen_n = 1'b1;
            end
         end
         default: w_state_n = S_IDLE;
      endcase
      if (w_grant) begin
         w_state_n         = S_SETUP;
         w_psel_n          = 1'b1;
         w_pen_n           = 1'b0;
         w_owner_n         = w_win;
         w_last_n          = w_win;
         w_ready_n[w_win]  = 1'b1;
         w_paddr_n         = w_win ? req1_addr  : req0_addr;
         w_pwrite_n        = w_win ? req1_write : req0_write;
         w_pwdata_n        = w_win ? req1_wdata : req0_wdata;
      end
   end

   always_ff @(posedge pclk or posedge preset_n) begin
      if (preset_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_last   <= 1'b1;
         r_owner  <= 1'b0;
         r_paddr  <= '0;
         r_pwrite <= 1'b0;
         r_pwdata <= '0;
         r_psel   <= 1'b0;
         r_pen    <= 1'b0;
         r_ready  <= '0;
         r_done   <= '0;
         r_err    <= '0;
         r_rdata  <= '0;
      end else begin
         r_state  <= w_state_n;
         r_cnt    <= w_cnt_n;
         r_last   <= w_last_n;
         r_owner  <= w_owner_n;
         r_paddr  <= w_paddr_n;
         r_pwrite <= w_pwrite_n;
         r_pwdata <= w_pwdata_n;
         r_psel   <= w_psel_n;
         r_pen    <= w_pen_n;
         r_ready  <= w_ready_n;
         r_done   <= w_done_n;
         r_err    <= w_err_n;
         r_rdata  <= w_rdata_n;
      end
   end

   assign paddr      = r_paddr;
   assign pwrite     = r_pwrite;
   assign pwdata     = r_pwdata;
   assign pselx      = r_psel;
   assign penable    = r_pen;
   assign req0_ready = r_ready[0];
   assign req1_ready = r_ready[1];
   assign req0_done  = r_done[0];
   assign req1_done  = r_done[1];
   assign req0_err   = r_err[0];
   assign req1_err   = r_err[1];
   assign req0_rdata = r_rdata[0];
   assign req1_rdata = r_rdata[1];
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a small wait-state APB slave memory model.
module tb_apb_master_arbiter;
   logic       pclk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_write, req0_ready, req0_done, req0_err;
   logic [7:0] req0_addr, req0_wdata, req0_rdata;
   logic       req1_valid, req1_write, req1_ready, req1_done, req1_err;
   logic [7:0] req1_addr, req1_wdata, req1_rdata;
   logic [7:0] paddr, pwdata, prdata;
   logic       pwrite, pselx, penable, pready, pslave_error;

   int checks = 0;
   int errors = 0;

   // slave model
   logic [7:0] mem [256];
   int         ws;
   int         acc_cnt;
   logic       hold, slv_err;

   assign pready       = pselx & penable & !hold & (acc_cnt >= ws);
   assign prdata       = mem[paddr];
   assign pslave_error = slv_err;

   always @(posedge pclk) begin
      if (pselx & penable & !pready) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (pselx & penable & pready & pwrite) mem[paddr] <= pwdata;
   end

   always #5 pclk = ~pclk;

   apb_master_arbiter #(.addr_width(8), .data_width(8), .TIMEOUT(16)) dut (
      .pclk(pclk), .preset_n(rst),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
      .req0_rdata(req0_rdata), .req0_err(req0_err),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
      .req1_rdata(req1_rdata), .req1_err(req1_err),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pselx(pselx),
      .penable(penable), .prdata(prdata), .pready(pready), .pslave_error(pslave_error)
   );

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      checks++;
      if ({pselx, penable, req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err} !== 8'h00 ||
          paddr !== 8'h00 || pwdata !== 8'h00 || pwrite !== 1'b0 || req0_rdata !== 8'h00 || req1_rdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs got psel=%b pen=%b paddr=%h pwdata=%h expected all 0", pselx, penable, paddr, pwdata);
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_write();
      req0_valid = 1; req0_write = 1; req0_addr = 8'h12; req0_wdata = 8'hA5; ws = 0;
      tick();
      checks++;
      if ({req0_ready, req1_ready, pselx, penable} !== 4'b1010 || paddr !== 8'h12 || pwdata !== 8'hA5 || pwrite !== 1'b1) begin
         errors++;
         $display("FAIL wr_setup got rdy0=%b rdy1=%b psel=%b pen=%b paddr=%h pwdata=%h exp 1 0 1 0 12 a5", req0_ready, req1_ready, pselx, penable, paddr, pwdata);
      end
      req0_valid = 0; req0_addr = 8'h00; req0_wdata = 8'h00;
      tick();
      checks++;
      if ({req0_ready, pselx, penable, req0_done} !== 4'b0110 || paddr !== 8'h12 || pwdata !== 8'hA5) begin
         errors++;
         $display("FAIL wr_access got rdy0=%b psel=%b pen=%b done0=%b paddr=%h exp 0 1 1 0 12", req0_ready, pselx, penable, req0_done, paddr);
      end
      tick();
      checks++;
      if ({req0_done, req0_err, req1_done, pselx, penable} !== 5'b10000 || mem[8'h12] !== 8'hA5) begin
         errors++;
         $display("FAIL wr_done got done0=%b err0=%b done1=%b psel=%b pen=%b mem=%h exp 1 0 0 0 0 a5", req0_done, req0_err, req1_done, pselx, penable, mem[8'h12]);
      end
      tick();
      checks++;
      if (req0_done !== 1'b0 || paddr !== 8'h12 || pwrite !== 1'b1) begin
         errors++;
         $display("FAIL wr_idle_hold got done0=%b paddr=%h pwrite=%b exp 0 12 1", req0_done, paddr, pwrite);
      end
   endtask

   task automatic test_read_wait();
      int bad = 0;
      req1_valid = 1; req1_write = 0; req1_addr = 8'h12; ws = 3;
      tick();
      checks++;
      if ({req1_ready, req0_ready, pselx, penable} !== 4'b1010) begin
         errors++;
         $display("FAIL rd_setup got rdy1=%b rdy0=%b psel=%b pen=%b exp 1 0 1 0", req1_ready, req0_ready, pselx, penable);
      end
      req1_valid = 0; req1_addr = 8'h77;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (penable !== 1'b1 || paddr !== 8'h12 || pwrite !== 1'b0 || req1_done !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rd_access_stable got %0d bad ACCESS cycles exp 0", bad);
      end
      tick();
      checks++;
      if ({req1_done, req1_err, penable, pselx} !== 4'b1000 || req1_rdata !== 8'hA5) begin
         errors++;
         $display("FAIL rd_done got done1=%b err1=%b pen=%b psel=%b rdata1=%h exp 1 0 0 0 a5", req1_done, req1_err, penable, pselx, req1_rdata);
      end
      tick();
      checks++;
      if (req1_done !== 1'b0 || req1_rdata !== 8'hA5) begin
         errors++;
         $display("FAIL rd_rdata_hold got done1=%b rdata1=%h exp 0 a5", req1_done, req1_rdata);
      end
   endtask

   task automatic test_slave_error();
      req0_valid = 1; req0_write = 0; req0_addr = 8'h12; ws = 0; slv_err = 1;
      tick();
      req0_valid = 0;
      tick();
      tick();
      checks++;
      if ({req0_done, req0_err} !== 2'b11 || req0_rdata !== 8'hA5) begin
         errors++;
         $display("FAIL slverr got done0=%b err0=%b rdata0=%h exp 1 1 a5", req0_done, req0_err, req0_rdata);
      end
      slv_err = 0;
      tick();
   endtask

   task automatic test_timeout();
      int bad = 0;
      req0_valid = 1; req0_write = 0; req0_addr = 8'h40; hold = 1;
      tick();
      req0_valid = 0;
      tick();
      for (int i = 0; i < 15; i++) begin
         if (penable !== 1'b1 || pselx !== 1'b1 || req0_done !== 1'b0) bad++;
         tick();
      end
      if (penable !== 1'b1 || req0_done !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL to_wait got %0d bad ACCESS cycles exp 0", bad);
      end
      tick();
      checks++;
      if ({req0_done, req0_err, pselx, penable} !== 4'b1100 || req0_rdata !== 8'h00) begin
         errors++;
         $display("FAIL to_abort got done0=%b err0=%b psel=%b pen=%b rdata0=%h exp 1 1 0 0 00", req0_done, req0_err, pselx, penable, req0_rdata);
      end
      hold = 0;
      tick();
      req1_valid = 1; req1_write = 1; req1_addr = 8'h41; req1_wdata = 8'h3C;
      tick();
      req1_valid = 0;
      tick();
      tick();
      checks++;
      if ({req1_done, req1_err} !== 2'b10 || mem[8'h41] !== 8'h3C || req1_rdata !== 8'h00) begin
         errors++;
         $display("FAIL to_next got done1=%b err1=%b mem=%h rdata1=%h exp 1 0 3c 00", req1_done, req1_err, mem[8'h41], req1_rdata);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [3:0] ord = 4'b0000;
      int nr = 0, r0 = 0, r1 = 0, d0 = 0, d1 = 0, drop = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0_valid = 1; req0_write = 1; req0_addr = 8'h20; req0_wdata = 8'h11;
      req1_valid = 1; req1_write = 1; req1_addr = 8'h30; req1_wdata = 8'h22;
      ws = 0;
      for (int i = 1; i <= 9; i++) begin
         tick();
         if (req0_ready) begin r0++; ord = {ord[2:0], 1'b0}; nr++; end
         if (req1_ready) begin r1++; ord = {ord[2:0], 1'b1}; nr++; end
         if (req0_done) d0++;
         if (req1_done) d1++;
         if (i <= 8 && pselx !== 1'b1) drop++;
         if (i == 7) begin req0_valid = 0; req1_valid = 0; end
      end
      checks++;
      if (nr != 4 || ord !== 4'b0101) begin
         errors++;
         $display("FAIL b2b_order got %0d grants order=%b exp 4 0101", nr, ord);
      end
      checks++;
      if (r0 != 2 || r1 != 2 || d0 != 2 || d1 != 2) begin
         errors++;
         $display("FAIL b2b_pulses got rdy %0d/%0d done %0d/%0d exp 2/2 2/2", r0, r1, d0, d1);
      end
      checks++;
      if (drop != 0 || pselx !== 1'b0 || mem[8'h20] !== 8'h11 || mem[8'h30] !== 8'h22) begin
         errors++;
         $display("FAIL b2b_psel got drops=%0d final psel=%b mem20=%h mem30=%h exp 0 0 11 22", drop, pselx, mem[8'h20], mem[8'h30]);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int late = 0;
      req1_valid = 1; req1_write = 1; req1_addr = 8'h50; req1_wdata = 8'h99; hold = 1;
      tick();
      req1_valid = 0;
      tick();
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({pselx, penable, req0_ready, req1_ready, req0_done, req1_done} !== 6'b000000) begin
         errors++;
         $display("FAIL rst_mid got psel=%b pen=%b rdy=%b%b done=%b%b exp all 0", pselx, penable, req0_ready, req1_ready, req0_done, req1_done);
      end
      hold = 0;
      req0_valid = 1; req0_write = 0; req0_addr = 8'h12;
      req1_valid = 1; req1_write = 0; req1_addr = 8'h30;
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10 || paddr !== 8'h12) begin
         errors++;
         $display("FAIL rst_tie got rdy0=%b rdy1=%b paddr=%h exp 1 0 12", req0_ready, req1_ready, paddr);
      end
      req0_valid = 0; req1_valid = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (req1_done) late++;
      end
      checks++;
      if (late != 0 || mem[8'h50] === 8'h99) begin
         errors++;
         $display("FAIL rst_drop got stray done1=%0d mem50=%h exp 0 not 99", late, mem[8'h50]);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      ws = 0; hold = 0; slv_err = 0;
      req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
      req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
      test_reset();
      test_single_write();
      test_read_wait();
      test_slave_error();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1);
   end
endmodule
